// File: rtl/nn_result_display.sv
// ---------------------------------------------------------------------------
// nn_result_display
//   Shows the digit produced by a classifier on one active-low seven-segment
//   display. Idle shows blank, a dash marks an inference in flight, and a
//   freshly accepted result is held on screen for HOLD_CYCLES before the next
//   result is accepted.
//
//   Optional feature macro: HEX_BLINK_EN -- when defined, the digit blinks
//   (digit/blank, BLINK_HALF cycles each) while in SHOW; HOLD is steady.
//
// Parameters
//   HOLD_CYCLES : cycles a new result stays in SHOW (result not accepted)
//   BLINK_HALF  : blink half-period in cycles (HEX_BLINK_EN only)
//
// Ports
//   CLOCK_50  in   clock, rising edge
//   KEY[0]    in   synchronous active-low reset
//   start     in   one-cycle pulse: an inference has begun
//   res_valid in   res_digit is valid
//   res_digit in   result value, 0-9 legal, 10-15 shown as "E"
//   res_ready out  result accepted this cycle when res_valid is also high
//   HEX0      out  registered segment drive, bit0=a .. bit6=g, active low
// ---------------------------------------------------------------------------
module nn_result_display #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int BLINK_HALF  = 12_500_000
) (
    input  logic       CLOCK_50,
    input  logic [0:0] KEY,
    input  logic       start,
    input  logic       res_valid,
    input  logic [3:0] res_digit,
    output logic       res_ready,
    output logic [6:0] HEX0
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHOW, S_HOLD} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [HW-1:0]   r_hold_cnt;
    logic [3:0]      r_digit;
    logic [6:0]      r_hex;
    logic [6:0]      w_hex_nxt;
    logic [6:0]      w_seg;
    logic            w_xfer;
    logic            w_blank_phase;

    assign w_xfer = res_valid && res_ready;
    assign HEX0   = r_hex;

    // ---------------------------------------------------------------------
    // Blink phase: restarts on every accepted result so SHOW always opens
    // with the digit visible.
    // ---------------------------------------------------------------------
`ifdef HEX_BLINK_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_off;

    always_ff @(posedge CLOCK_50) begin
        if (!KEY[0]) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (w_xfer) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (r_state == S_SHOW) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_off <= ~r_blink_off;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    assign w_blank_phase = r_blink_off;
`else
    logic w_unused_blink;
    assign w_unused_blink = (BLINK_HALF > 0);
    assign w_blank_phase  = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!KEY[0]) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state. A transfer always wins over a coincident start.
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_xfer)     w_state_nxt = S_SHOW;
                else if (start) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_xfer)     w_state_nxt = S_SHOW;
            end
            S_SHOW: begin
                // res_ready is low here, so neither start nor valid matter
                if (r_hold_cnt == HOLD_LAST) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (w_xfer)     w_state_nxt = S_SHOW;
                else if (start) w_state_nxt = S_WAIT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs (ready is combinational from state, segment value is
    // computed here and registered below)
    // ---------------------------------------------------------------------
    always_comb begin
        case (r_digit)
            4'd0:    w_seg = 7'b1000000;
            4'd1:    w_seg = 7'b1111001;
            4'd2:    w_seg = 7'b0100100;
            4'd3:    w_seg = 7'b0110000;
            4'd4:    w_seg = 7'b0011001;
            4'd5:    w_seg = 7'b0010010;
            4'd6:    w_seg = 7'b0000010;
            4'd7:    w_seg = 7'b1111000;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0010000;
            default: w_seg = 7'b0000110;  // out-of-range result shows "E"
        endcase
    end

    always_comb begin
        res_ready = (r_state != S_SHOW);
        w_hex_nxt = SEG_BLANK;
        case (r_state)
            S_IDLE:  w_hex_nxt = SEG_BLANK;
            S_WAIT:  w_hex_nxt = SEG_DASH;
            S_SHOW:  w_hex_nxt = w_blank_phase ? SEG_BLANK : w_seg;
            S_HOLD:  w_hex_nxt = w_seg;
            default: w_hex_nxt = SEG_BLANK;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: latched digit, hold counter, registered display.
    // The display register follows state/digit by one cycle, so a result
    // accepted at edge N appears after edge N+1.
    // ---------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!KEY[0]) begin
            r_digit    <= 4'd0;
            r_hold_cnt <= '0;
            r_hex      <= SEG_BLANK;
        end else begin
            r_hex <= w_hex_nxt;
            if (w_xfer) begin
                r_digit    <= res_digit;
                r_hold_cnt <= '0;
            end else if (r_state == S_SHOW && r_hold_cnt != HOLD_LAST) begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
            end
        end
    end

endmodule

// File: tb/tb_nn_result_display.sv
module tb_nn_result_display;

    logic       CLOCK_50 = 1'b0;
    logic [0:0] KEY;
    logic       start;
    logic       res_valid;
    logic [3:0] res_digit;
    logic       res_ready;
    logic [6:0] HEX0;

    always #5 CLOCK_50 = ~CLOCK_50;

    nn_result_display #(
        .HOLD_CYCLES (8),
        .BLINK_HALF  (2)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .KEY       (KEY),
        .start     (start),
        .res_valid (res_valid),
        .res_digit (res_digit),
        .res_ready (res_ready),
        .HEX0      (HEX0)
    );

`ifdef HEX_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    localparam logic [6:0] BL   = 7'b1111111;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] D0   = 7'b1000000;
    localparam logic [6:0] D3   = 7'b0110000;
    localparam logic [6:0] D7   = 7'b1111000;
    localparam logic [6:0] DE   = 7'b0000110;

    typedef struct {
        logic       rst_n;
        logic       st;
        logic       vld;
        logic [3:0] dig;
        logic [6:0] hex;
        logic       rdy;
    } vec_t;

    vec_t       tv[$];
    logic [6:0] enc [16];
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic void add(logic rst_n, logic st, logic vld, logic [3:0] dig,
                                logic [6:0] hex, logic rdy);
        vec_t v;
        v.rst_n = rst_n; v.st = st; v.vld = vld; v.dig = dig; v.hex = hex; v.rdy = rdy;
        tv.push_back(v);
    endfunction

    // Expected SHOW display k edges into a row block starting at base:
    // two cycles digit, two cycles blank when blinking is built in.
    function automatic logic [6:0] bl(logic [6:0] d, int k, int base);
        return (BLINK && (((k - base) / 2) % 2 == 1)) ? BL : d;
    endfunction

    task automatic chk(input string nm, input logic [6:0] got, input logic [6:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic step(input logic rst_n, input logic st, input logic vld, input logic [3:0] d);
        KEY[0]    = rst_n;
        start     = st;
        res_valid = vld;
        res_digit = d;
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        KEY = 1'b0; start = 1'b0; res_valid = 1'b0; res_digit = 4'd0;

        enc[0]  = 7'b1000000; enc[1]  = 7'b1111001; enc[2]  = 7'b0100100;
        enc[3]  = 7'b0110000; enc[4]  = 7'b0011001; enc[5]  = 7'b0010010;
        enc[6]  = 7'b0000010; enc[7]  = 7'b1111000; enc[8]  = 7'b0000000;
        enc[9]  = 7'b0010000;
        for (int i = 10; i < 16; i++) enc[i] = 7'b0000110;

        // Row index == clock edge number. Display lags state by one edge.
        add(0, 0, 0, 0,  BL,   1);                   // 0  reset
        add(0, 0, 0, 0,  BL,   1);                   // 1  reset
        add(1, 0, 0, 0,  BL,   1);                   // 2  idle
        add(1, 1, 0, 0,  BL,   1);                   // 3  start -> WAIT
        add(1, 0, 0, 0,  DASH, 1);                   // 4  dash shown
        add(1, 0, 1, 7,  DASH, 0);                   // 5  transfer 7 -> SHOW
        for (int k = 6; k <= 13; k++)                // 6..13 SHOW 7, HOLD after 13
            add(1, 0, 0, 0, bl(D7, k, 6), (k == 13));
        add(1, 0, 0, 0,  D7,   1);                   // 14 HOLD steady
        add(1, 0, 1, 12, D7,   0);                   // 15 transfer 12 from HOLD
        for (int k = 16; k <= 23; k++)               // 16..23 valid 3 held, stalled
            add(1, 0, 1, 3, bl(DE, k, 16), (k == 23));
        add(1, 0, 1, 3,  DE,   0);                   // 24 3 accepted in HOLD
        for (int k = 25; k <= 32; k++)               // 25..32 SHOW 3
            add(1, 0, 0, 0, bl(D3, k, 25), (k == 32));
        add(1, 1, 1, 0,  D3,   0);                   // 33 start+transfer -> SHOW
        for (int k = 34; k <= 36; k++)               // 34..36 start at 35 ignored
            add(1, (k == 35), 0, 0, bl(D0, k, 34), 0);
        add(0, 0, 0, 0,  BL,   1);                   // 37 reset in 4th SHOW cycle
        add(1, 0, 0, 0,  BL,   1);                   // 38 IDLE, no residual digit

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].rst_n, tv[i].st, tv[i].vld, tv[i].dig);
            chk($sformatf("vec%0d hex", i), HEX0, tv[i].hex);
            chk($sformatf("vec%0d ready", i), {6'd0, res_ready}, {6'd0, tv[i].rdy});
        end

        // Every encoding: accept, check digit one edge later, run out the hold.
        for (int d = 0; d < 16; d++) begin
            step(1, 0, 1, 4'(d));
            chk($sformatf("dig%0d ready-low", d), {6'd0, res_ready}, 7'd0);
            step(1, 0, 0, 0);
            chk($sformatf("dig%0d hex", d), HEX0, enc[d]);
            for (int c = 0; c < 7; c++) step(1, 0, 0, 0);
            chk($sformatf("dig%0d ready-hold", d), {6'd0, res_ready}, 7'd1);
        end

        // A reset pulse between edges must not be seen.
        step(1, 0, 1, 2);
        chk("glitch pre ready", {6'd0, res_ready}, 7'd0);
        res_valid = 1'b0;
        #2 KEY[0] = 1'b0;
        #2 KEY[0] = 1'b1;
        @(posedge CLOCK_50);
        #1;
        chk("glitch ready", {6'd0, res_ready}, 7'd0);
        chk("glitch hex", HEX0, enc[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nn_result_display.md
NN_RESULT_DISPLAY -- requirements
Module: nn_result_display

Interface
REQ-001 Parameter HOLD_CYCLES, default 50_000_000: minimum cycles a new result stays displayed before another result is accepted.
REQ-002 Parameter BLINK_HALF, default 12_500_000: cycles per blink half-period, used only when HEX_BLINK_EN is defined.
REQ-003 Port CLOCK_50, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port KEY, input, 1 bit: KEY[0] is the reset, synchronous and active-low.
REQ-005 Port start, input, 1 bit: single-cycle pulse indicating that an inference has begun.
REQ-006 Port res_valid, input, 1 bit: res_digit is valid this cycle.
REQ-007 Port res_digit, input, 4 bits: classification result, 0-9 legal.
REQ-008 Port res_ready, output, 1 bit: the block accepts a result this cycle.
REQ-009 Port HEX0, output, 7 bits: active-low seven-segment drive; bit 0 = segment a through bit 6 = segment g.

Function
REQ-010 The FSM SHALL have states IDLE, WAIT, SHOW and HOLD.
- IDLE: HEX0 = 7'b1111111 (blank).
- WAIT: HEX0 = 7'b0111111 (dash).
- SHOW and HOLD: HEX0 shows the latched digit.
REQ-011 Transfer SHALL occur exactly when res_valid && res_ready are both high at a rising edge; res_digit is then latched into a 4-bit register.
REQ-012 res_ready SHALL be high in IDLE, WAIT and HOLD, and low in SHOW.
REQ-013 The state transitions SHALL be:
- IDLE->WAIT on start with no transfer.
- Any state except SHOW ->SHOW on transfer.
- WAIT->WAIT otherwise.
- SHOW->HOLD when the hold counter reaches HOLD_CYCLES-1.
- HOLD->WAIT on start.
REQ-014 On entry to SHOW the hold counter SHALL clear to 0; it increments once per cycle in SHOW and saturates; it does not count in other states.
REQ-015 A transfer and a start pulse in the same cycle SHALL resolve to the transfer, giving next state SHOW.
REQ-016 A start pulse in SHOW SHALL be ignored.
REQ-017 The digit encoding SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Values 10-15 SHALL display "E" = 0000110.
REQ-018 HEX0 SHALL be registered: the display reflects a state or digit change one cycle after the edge that caused it.
REQ-019 The latency from a transfer edge to HEX0 showing the new digit SHALL be exactly 1 cycle.

Reset
REQ-020 While KEY[0]=0 at a rising edge, the block SHALL enter IDLE, clear the hold counter, blink counter and latched digit to 0, set HEX0=7'b1111111, and drive res_ready high from the next cycle.
REQ-021 A reset asserted mid-SHOW or mid-HOLD SHALL abort the display immediately, with no residual digit shown.
REQ-022 The reset SHALL be synchronous only: asserting KEY[0] between clock edges SHALL have no effect until the next edge.

Configuration
REQ-023 The macro HEX_BLINK_EN SHALL control blinking.
- Defined: in SHOW, HEX0 alternates digit/blank every BLINK_HALF cycles, starting with the digit on SHOW entry; HOLD shows the digit steadily.
- Undefined: SHOW shows the digit steadily, and the blink counter is not instantiated.

Verification
REQ-024 The bench SHALL cover these scenarios, using HOLD_CYCLES=8 and BLINK_HALF=2:
- Reset: KEY[0]=0 for 2 cycles -> HEX0=1111111, res_ready=1.
- Start then result: start pulse -> HEX0=0111111 next cycle; res_digit=7 with res_valid -> HEX0=1111000 one cycle later, res_ready=0 for 8 cycles, then 1.
- Illegal digit: res_digit=12 -> HEX0=0000110.
- Back-pressure and simultaneous events: res_valid held with digit 3 during SHOW -> no transfer until HOLD; a start and a transfer in the same cycle -> SHOW.
- Mid-operation reset: KEY[0]=0 at cycle 4 of SHOW -> HEX0=1111111, state IDLE next cycle.
- Blink (HEX_BLINK_EN defined): digit 5 -> HEX0 pattern 0010010 x2, 1111111 x2, repeating until HOLD, then steady 0010010.
